// File: rtl/wib_tx_arbiter.sv
// WIB timing-TX request arbiter: synchronises and debounces the active-low BP_IO
// requests, grants one WIB at a time and sequences SFP2 TX enable around mux changes.
module wib_tx_arbiter #(
    parameter int N_WIB       = 6,
    parameter int SEL_W       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16,
    parameter int GUARD       = 8,
    parameter int MAX_HOLD    = 0,
    parameter int IDLE_SEL    = 7
) (
    input  logic               clk_axi,
    input  logic               srst,
    input  logic [N_WIB-1:0]   bp_io_n,
    input  logic               arb_en,
    input  logic               rr_mode,
    input  logic [N_WIB-1:0]   req_mask,
    input  logic               err_clr,
    output logic [SEL_W-1:0]   wib_rx_sel,
    output logic               sfp2_tx_en,
    output logic               grant_valid,
    output logic [SEL_W-1:0]   grant_id,
    output logic [N_WIB-1:0]   req_filt,
    output logic               timeout_err,
    output logic [15:0]        grant_cnt
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int GD_W = $clog2(GUARD + 1);
    localparam int HD_W = $clog2(MAX_HOLD + 2);
    localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(IDLE_SEL);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_WIB - 1);
    localparam logic [SEL_W:0]   IDX_WRAP = (SEL_W + 1)'(N_WIB);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    logic [N_WIB-1:0] r_sync [SYNC_STAGES];
    logic [DB_W-1:0]  r_db_cnt [N_WIB];
    logic [N_WIB-1:0] r_req_filt;
    logic [N_WIB-1:0] r_lockout;
    state_t           r_state;
    logic [GD_W-1:0]  r_guard;
    logic [HD_W-1:0]  r_hold;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_grant_id;
    logic             r_tx_en;
    logic             r_grant_valid;
    logic             r_timeout_err;
    logic [15:0]      r_grant_cnt;

    logic [N_WIB-1:0] w_req_raw;
    logic [N_WIB-1:0] w_elig;
    logic [SEL_W-1:0] w_base;
    logic [SEL_W:0]   w_idx;
    logic [SEL_W-1:0] w_winner;
    logic             w_found;
    logic             w_drop;

    // Request synchroniser chain (requests arrive inverted on BP_IO)
    always_ff @(posedge clk_axi) begin
        if (srst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= {N_WIB{1'b0}};
            end
        end else begin
            r_sync[0] <= ~bp_io_n;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_req_raw = r_sync[SYNC_STAGES-1];

    // Per-line debounce: filtered value flips after DEBOUNCE consecutive differing cycles
    always_ff @(posedge clk_axi) begin
        if (srst) begin
            r_req_filt <= {N_WIB{1'b0}};
            for (int i = 0; i < N_WIB; i++) begin
                r_db_cnt[i] <= {DB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_WIB; i++) begin
                if (w_req_raw[i] != r_req_filt[i]) begin
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                        r_req_filt[i] <= w_req_raw[i];
                        r_db_cnt[i]   <= {DB_W{1'b0}};
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    assign w_elig = r_req_filt & ~req_mask & ~r_lockout;
    assign w_base = rr_mode ? r_ptr : {SEL_W{1'b0}};
    assign w_drop = ~r_req_filt[r_grant_id] | req_mask[r_grant_id] | ~arb_en;

    // Winner search: first eligible index starting at w_base, wrapping at N_WIB
    always_comb begin
        w_winner = {SEL_W{1'b0}};
        w_found  = 1'b0;
        w_idx    = {(SEL_W + 1){1'b0}};
        for (int k = 0; k < N_WIB; k++) begin
            w_idx = {1'b0, w_base} + (SEL_W + 1)'(k);
            if (w_idx >= IDX_WRAP) begin
                w_idx = w_idx - IDX_WRAP;
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && w_elig[w_idx[SEL_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[SEL_W-1:0];
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Grant FSM with registered mux select, TX enable and bookkeeping
    always_ff @(posedge clk_axi) begin
        if (srst) begin
            r_state       <= ST_IDLE;
            r_guard       <= {GD_W{1'b0}};
            r_hold        <= {HD_W{1'b0}};
            r_ptr         <= {SEL_W{1'b0}};
            r_sel         <= SEL_IDLE;
            r_grant_id    <= {SEL_W{1'b0}};
            r_tx_en       <= 1'b0;
            r_grant_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_grant_cnt   <= 16'd0;
            r_lockout     <= {N_WIB{1'b0}};
        end else begin
            r_lockout <= r_lockout & r_req_filt;
            if (err_clr) begin
                r_timeout_err <= 1'b0;
            end else begin
                r_timeout_err <= r_timeout_err;
            end
            case (r_state)
                ST_IDLE: begin
                    if (arb_en && w_found) begin
                        r_state       <= ST_SELECT;
                        r_grant_id    <= w_winner;
                        r_sel         <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_grant_cnt   <= r_grant_cnt + 16'd1;
                        r_guard       <= GD_W'(GUARD - 1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (w_drop) begin
                        r_state <= ST_RELEASE;
                        r_guard <= GD_W'(GUARD - 1);
                    end else if (r_guard == {GD_W{1'b0}}) begin
                        r_state <= ST_ACTIVE;
                        r_tx_en <= 1'b1;
                        r_hold  <= HD_W'(1);
                        r_ptr   <= (r_grant_id == SEL_LAST) ? {SEL_W{1'b0}}
                                                            : r_grant_id + SEL_W'(1);
                    end else begin
                        r_guard <= r_guard - GD_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (w_drop) begin
                        r_state <= ST_RELEASE;
                        r_tx_en <= 1'b0;
                        r_guard <= GD_W'(GUARD - 1);
                    end else if (MAX_HOLD != 0 && r_hold == HD_W'(MAX_HOLD)) begin
                        r_state                <= ST_RELEASE;
                        r_tx_en                <= 1'b0;
                        r_guard                <= GD_W'(GUARD - 1);
                        r_timeout_err          <= 1'b1;
                        r_lockout[r_grant_id]  <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_guard == {GD_W{1'b0}}) begin
                        r_state       <= ST_IDLE;
                        r_sel         <= SEL_IDLE;
                        r_grant_valid <= 1'b0;
                    end else begin
                        r_guard <= r_guard - GD_W'(1);
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_tx_en       <= 1'b0;
                    r_grant_valid <= 1'b0;
                    r_sel         <= SEL_IDLE;
                end
            endcase
        end
    end

    assign wib_rx_sel  = r_sel;
    assign sfp2_tx_en  = r_tx_en;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign req_filt    = r_req_filt;
    assign timeout_err = r_timeout_err;
    assign grant_cnt   = r_grant_cnt;

endmodule

// File: tb/tb_wib_tx_arbiter.sv
// Bench for wib_tx_arbiter: vector table, hand-written corner sequences and a
// randomized run, all shadowed every cycle by a behavioural reference model.
module tb_wib_tx_arbiter;

    localparam int N = 6, SW = 3, SYNC = 2, DB = 16, GD = 8, MH = 40, ISEL = 7;
    localparam int PH_IDLE = 0, PH_SEL = 1, PH_ACT = 2, PH_REL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst, arb_en, rr_mode, err_clr;
    logic [N-1:0]  bp_io_n, req_mask;
    logic [SW-1:0] wib_rx_sel, grant_id;
    logic          sfp2_tx_en, grant_valid, timeout_err;
    logic [N-1:0]  req_filt;
    logic [15:0]   grant_cnt;

    wib_tx_arbiter #(.N_WIB(N), .SEL_W(SW), .SYNC_STAGES(SYNC), .DEBOUNCE(DB),
                     .GUARD(GD), .MAX_HOLD(MH), .IDLE_SEL(ISEL)) dut (
        .clk_axi(clk), .srst(srst), .bp_io_n(bp_io_n), .arb_en(arb_en),
        .rr_mode(rr_mode), .req_mask(req_mask), .err_clr(err_clr),
        .wib_rx_sel(wib_rx_sel), .sfp2_tx_en(sfp2_tx_en), .grant_valid(grant_valid),
        .grant_id(grant_id), .req_filt(req_filt), .timeout_err(timeout_err),
        .grant_cnt(grant_cnt));

    int vectors = 0, miscompares = 0;

    // Reference model state
    logic [N-1:0] m_filt, m_lock;
    logic [N-1:0] m_pipe[$];
    int           m_run[N];
    int           m_phase, m_age, m_gid, m_ptr;
    bit           m_err;
    logic [15:0]  m_cnt;

    typedef struct {
        logic [N-1:0]  bp;
        logic          en;
        logic [N-1:0]  mask;
        int            ticks;
        logic [N-1:0]  filt;
        logic [SW-1:0] sel;
        logic          tx;
        logic          gv;
        logic [15:0]   cnt;
    } vec_t;
    vec_t tbl[$];

    int order[3] = '{0, 1, 3};

    function automatic int pick(logic [N-1:0] elig, bit rr, int ptr);
        int start = rr ? ptr : 0;
        for (int k = 0; k < N; k++) begin
            int i = (start + k) % N;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] raw, old_filt, elig;
        bit drop, tmo;
        int w;
        if (srst) begin
            m_filt = '0; m_lock = '0; m_pipe = {};
            for (int s = 0; s < SYNC; s++) m_pipe.push_back('0);
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_phase = PH_IDLE; m_age = 0; m_gid = 0; m_ptr = 0; m_err = 0; m_cnt = 16'd0;
            return;
        end
        raw = m_pipe.pop_front();
        m_pipe.push_back(~bp_io_n);
        old_filt = m_filt;
        elig = old_filt & ~req_mask & ~m_lock;
        drop = !old_filt[m_gid] || req_mask[m_gid] || !arb_en;
        tmo = 0;
        case (m_phase)
            PH_IDLE: begin
                w = pick(elig, rr_mode, m_ptr);
                if (arb_en && w >= 0) begin
                    m_phase = PH_SEL; m_age = 1; m_gid = w; m_cnt = m_cnt + 16'd1;
                end
            end
            PH_SEL: begin
                if (drop) begin m_phase = PH_REL; m_age = 1; end
                else if (m_age == GD) begin m_phase = PH_ACT; m_age = 1; m_ptr = (m_gid + 1) % N; end
                else m_age++;
            end
            PH_ACT: begin
                if (drop) begin m_phase = PH_REL; m_age = 1; end
                else if (MH != 0 && m_age == MH) begin m_phase = PH_REL; m_age = 1; tmo = 1; end
                else m_age++;
            end
            PH_REL: begin
                if (m_age == GD) begin m_phase = PH_IDLE; m_age = 0; end
                else m_age++;
            end
            default: m_phase = PH_IDLE;
        endcase
        m_lock = m_lock & old_filt;
        if (tmo) m_lock[m_gid] = 1'b1;
        if (tmo) m_err = 1;
        else if (err_clr) m_err = 0;
        for (int i = 0; i < N; i++) begin
            if (raw[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin m_filt[i] = raw[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [SW-1:0] e_sel = (m_phase == PH_IDLE) ? SW'(ISEL) : SW'(m_gid);
        logic e_tx = (m_phase == PH_ACT);
        logic e_gv = (m_phase != PH_IDLE);
        bit bad = (wib_rx_sel !== e_sel) || (sfp2_tx_en !== e_tx) || (grant_valid !== e_gv) ||
                  (e_gv && grant_id !== SW'(m_gid)) || (req_filt !== m_filt) ||
                  (timeout_err !== m_err) || (grant_cnt !== m_cnt);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL model @%0t: got sel=%0d tx=%0b gv=%0b id=%0d filt=%b err=%0b cnt=%0d, want sel=%0d tx=%0b gv=%0b id=%0d filt=%b err=%0b cnt=%0d",
                     $time, wib_rx_sel, sfp2_tx_en, grant_valid, grant_id, req_filt, timeout_err, grant_cnt,
                     e_sel, e_tx, e_gv, m_gid, m_filt, m_err, m_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic wait_tx(input logic val, input int limit, input string name, output int n);
        n = 0;
        while (sfp2_tx_en !== val && n < limit) begin
            tick();
            n++;
        end
        if (sfp2_tx_en !== val) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: tx_en=%0b after %0d cycles, want %0b", name, sfp2_tx_en, n, val);
        end
    endtask

    task automatic do_reset();
        srst = 1'b1;
        repeat (3) tick();
        srst = 1'b0;
    endtask

    initial begin
        int n, hold, seen, ix;
        srst = 1'b1; bp_io_n = 6'b111111; arb_en = 1'b1; rr_mode = 1'b0;
        req_mask = 6'b000000; err_clr = 1'b0;
        do_reset();
        check("rst_sel", wib_rx_sel, ISEL);
        check("rst_tx", sfp2_tx_en, 0);
        check("rst_gv", grant_valid, 0);
        check("rst_gid", grant_id, 0);
        check("rst_filt", req_filt, 0);
        check("rst_err", timeout_err, 0);
        check("rst_cnt", grant_cnt, 0);

        //            bp         en    mask       ticks filt       sel   tx    gv    cnt
        tbl.push_back('{6'b111110, 1'b1, 6'b000000, 18, 6'b000001, 3'd7, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{6'b111110, 1'b1, 6'b000000, 1,  6'b000001, 3'd0, 1'b0, 1'b1, 16'd1});
        tbl.push_back('{6'b111110, 1'b1, 6'b000000, 7,  6'b000001, 3'd0, 1'b0, 1'b1, 16'd1});
        tbl.push_back('{6'b111110, 1'b1, 6'b000000, 1,  6'b000001, 3'd0, 1'b1, 1'b1, 16'd1});
        tbl.push_back('{6'b111111, 1'b1, 6'b000000, 18, 6'b000000, 3'd0, 1'b1, 1'b1, 16'd1});
        tbl.push_back('{6'b111111, 1'b1, 6'b000000, 1,  6'b000000, 3'd0, 1'b0, 1'b1, 16'd1});
        tbl.push_back('{6'b111111, 1'b1, 6'b000000, 7,  6'b000000, 3'd0, 1'b0, 1'b1, 16'd1});
        tbl.push_back('{6'b111111, 1'b1, 6'b000000, 1,  6'b000000, 3'd7, 1'b0, 1'b0, 16'd1});
        tbl.push_back('{6'b111011, 1'b1, 6'b000000, 3,  6'b000000, 3'd7, 1'b0, 1'b0, 16'd1});
        tbl.push_back('{6'b111111, 1'b1, 6'b000000, 40, 6'b000000, 3'd7, 1'b0, 1'b0, 16'd1});
        tbl.push_back('{6'b111110, 1'b1, 6'b000001, 30, 6'b000001, 3'd7, 1'b0, 1'b0, 16'd1});
        tbl.push_back('{6'b111110, 1'b1, 6'b000000, 1,  6'b000001, 3'd0, 1'b0, 1'b1, 16'd2});
        tbl.push_back('{6'b111110, 1'b0, 6'b000000, 1,  6'b000001, 3'd0, 1'b0, 1'b1, 16'd2});
        tbl.push_back('{6'b111110, 1'b0, 6'b000000, 8,  6'b000001, 3'd7, 1'b0, 1'b0, 16'd2});
        tbl.push_back('{6'b111110, 1'b0, 6'b000000, 20, 6'b000001, 3'd7, 1'b0, 1'b0, 16'd2});
        tbl.push_back('{6'b111110, 1'b1, 6'b000000, 1,  6'b000001, 3'd0, 1'b0, 1'b1, 16'd3});
        tbl.push_back('{6'b111111, 1'b1, 6'b000000, 40, 6'b000000, 3'd7, 1'b0, 1'b0, 16'd3});

        for (int r = 0; r < tbl.size(); r++) begin
            bp_io_n = tbl[r].bp; arb_en = tbl[r].en; req_mask = tbl[r].mask;
            repeat (tbl[r].ticks) tick();
            vectors++;
            if (req_filt !== tbl[r].filt || wib_rx_sel !== tbl[r].sel || sfp2_tx_en !== tbl[r].tx ||
                grant_valid !== tbl[r].gv || grant_cnt !== tbl[r].cnt) begin
                miscompares++;
                $display("FAIL table row %0d: got filt=%b sel=%0d tx=%0b gv=%0b cnt=%0d, want filt=%b sel=%0d tx=%0b gv=%0b cnt=%0d",
                         r, req_filt, wib_rx_sel, sfp2_tx_en, grant_valid, grant_cnt,
                         tbl[r].filt, tbl[r].sel, tbl[r].tx, tbl[r].gv, tbl[r].cnt);
            end
        end

        // Round robin across WIBs 0,1,3, each dropped once granted
        do_reset();
        rr_mode = 1'b1; bp_io_n = 6'b110100;
        for (int k = 0; k < 3; k++) begin
            wait_tx(1'b1, 200, "rr_grant", n);
            if (k > 0) check("rr_tx_off_gap_ge_2guard", int'(n >= 2 * GD), 1);
            check("rr_grant_id", grant_id, order[k]);
            bp_io_n[order[k]] = 1'b1;
            wait_tx(1'b0, 100, "rr_release", n);
        end
        bp_io_n = 6'b111111; rr_mode = 1'b0;
        repeat (30) tick();

        // MAX_HOLD timeout, lockout and sticky error
        do_reset();
        bp_io_n = 6'b101111;
        wait_tx(1'b1, 100, "to_grant", n);
        check("to_grant_id", grant_id, 4);
        hold = 1;
        while (sfp2_tx_en === 1'b1 && hold < 200) begin
            tick();
            if (sfp2_tx_en === 1'b1) hold++;
        end
        check("to_hold_cycles", hold, MH);
        check("to_err_set", timeout_err, 1);
        seen = 0;
        repeat (60) begin tick(); if (sfp2_tx_en === 1'b1) seen++; end
        check("to_lockout_no_tx", seen, 0);
        check("to_lockout_cnt", grant_cnt, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_clr", timeout_err, 0);
        bp_io_n = 6'b111111;
        repeat (25) tick();
        bp_io_n = 6'b101111;
        wait_tx(1'b1, 100, "to_regrant", n);
        check("to_regrant_cnt", grant_cnt, 2);
        err_clr = 1'b1;
        wait_tx(1'b0, 100, "to_second_timeout", n);
        check("err_set_wins_over_clr", timeout_err, 1);
        err_clr = 1'b0;
        bp_io_n = 6'b111111;
        repeat (30) tick();

        // arb_en drop mid-ACTIVE, then srst mid-ACTIVE
        do_reset();
        bp_io_n = 6'b111110;
        wait_tx(1'b1, 100, "en_grant", n);
        arb_en = 1'b0; tick();
        check("en_off_tx", sfp2_tx_en, 0);
        check("en_off_gv", grant_valid, 1);
        repeat (GD) tick();
        check("en_off_idle_gv", grant_valid, 0);
        check("en_off_idle_sel", wib_rx_sel, ISEL);
        seen = 0;
        repeat (30) begin tick(); if (grant_valid === 1'b1) seen++; end
        check("en_off_no_grant", seen, 0);
        arb_en = 1'b1;
        wait_tx(1'b1, 100, "srst_grant", n);
        srst = 1'b1; tick(); srst = 1'b0;
        check("srst_tx", sfp2_tx_en, 0);
        check("srst_sel", wib_rx_sel, ISEL);
        check("srst_cnt", grant_cnt, 0);
        check("srst_gv", grant_valid, 0);

        // Randomized run against the model
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(47) == 0) bp_io_n[i] = ~bp_io_n[i];
            if ($urandom_range(299) == 0) begin
                ix = $urandom_range(N - 1);
                req_mask[ix] = ~req_mask[ix];
            end
            if ($urandom_range(199) == 0) arb_en = ~arb_en;
            if ($urandom_range(399) == 0) rr_mode = ~rr_mode;
            err_clr = ($urandom_range(99) == 0);
            srst = ($urandom_range(2999) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
